// File: rtl/amstrad_crtc_pkg.sv
// amstrad_crtc_pkg: register indices, reset defaults, write masks and vertical state for the CPC CRTC
package amstrad_crtc_pkg;
  localparam int R_HTOTAL    = 0;
  localparam int R_HDISP     = 1;
  localparam int R_HSYNC_POS = 2;
  localparam int R_SYNC_W    = 3;
  localparam int R_VTOTAL    = 4;
  localparam int R_VADJ      = 5;
  localparam int R_VDISP     = 6;
  localparam int R_VSYNC_POS = 7;
  localparam int R_MODE      = 8;
  localparam int R_MAX_RA    = 9;
  localparam int R_CURSOR_S  = 10;
  localparam int R_CURSOR_E  = 11;
  localparam int R_START_H   = 12;
  localparam int R_START_L   = 13;
  localparam int R_CURSOR_H  = 14;
  localparam int R_CURSOR_L  = 15;
  localparam logic [15:0][7:0] REG_RESET = {
    8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'd7, 8'h00,
    8'd30, 8'd25, 8'd0, 8'd38, 8'h8E, 8'd46, 8'd40, 8'd63};
  localparam logic [15:0][7:0] REG_MASK = {
    8'hFF, 8'h3F, 8'hFF, 8'h3F, 8'hFF, 8'hFF, 8'h1F, 8'hFF,
    8'h7F, 8'h7F, 8'h1F, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  typedef enum logic {V_ACTIVE, V_ADJUST} vstate_e;
endpackage

// File: rtl/amstrad_crtc_regs.sv
// amstrad_crtc_regs: select latch, masked register file and registered read-back mux
module amstrad_crtc_regs
  import amstrad_crtc_pkg::*;
#(
  parameter logic [7:0] R31_VAL = 8'hFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sel_we_i,
  input  logic              data_we_i,
  input  logic              data_re_i,
  input  logic [7:0]        d_i,
  output logic [7:0]        q_o,
  output logic [15:0][7:0]  regs_o
);
  logic [4:0]       sel_q;
  logic [15:0][7:0] regs_q;
  logic [7:0]       q_q, q_d;
  always_comb q_d = (sel_q == 5'd14 || sel_q == 5'd15) ? regs_q[sel_q[3:0]] :
                    (sel_q == 5'd31) ? R31_VAL : 8'h00;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q  <= '0;
      regs_q <= REG_RESET;
      q_q    <= '0;
    end else begin
      if (sel_we_i) sel_q <= d_i[4:0];
      if (data_we_i && !sel_q[4]) regs_q[sel_q[3:0]] <= d_i & REG_MASK[sel_q[3:0]];
      if (data_re_i) q_q <= q_d;
    end
  end
  assign q_o    = q_q;
  assign regs_o = regs_q;
endmodule

// File: rtl/amstrad_crtc.sv
// amstrad_crtc: UM6845R (type 1) character-clock CRTC producing sync, display enable, MA and RA
module amstrad_crtc
  import amstrad_crtc_pkg::*;
#(
  parameter int VSYNC_LINES = 16,
  parameter int CRTC_TYPE   = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        SEL_WE,
  input  logic        DATA_WE,
  input  logic        DATA_RE,
  input  logic [7:0]  D,
  output logic [7:0]  Q,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic [13:0] MA,
  output logic [4:0]  RA
);
  logic [15:0][7:0] r;
  logic [7:0]  hcc_q, hcc_d;
  logic [4:0]  raster_q, raster_d, vadj_q, vadj_d, vsw_q, vsw_d;
  logic [6:0]  vcc_q, vcc_d;
  logic [3:0]  hsw_q, hsw_d;
  logic [13:0] ma_row_q, ma_row_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, hdisp_q, hdisp_d, vdisp_q, vdisp_d;
  vstate_e     vstate_q, vstate_d;
  logic        eol, new_frame, row_start, hs_start, vs_start;
  logic        unused;

  amstrad_crtc_regs #(.R31_VAL(CRTC_TYPE == 1 ? 8'hFF : 8'h00)) u_regs (
    .clk_i(CLK), .rst_i(RESET), .sel_we_i(SEL_WE), .data_we_i(DATA_WE),
    .data_re_i(DATA_RE), .d_i(D), .q_o(Q), .regs_o(r)
  );

  assign unused = ^{r[R_MODE], r[R_CURSOR_S], r[R_CURSOR_E], r[R_CURSOR_H], r[R_CURSOR_L],
                    r[R_SYNC_W][7:4], r[R_VTOTAL][7], r[R_VDISP][7], r[R_VSYNC_POS][7],
                    r[R_VADJ][7:5], r[R_MAX_RA][7:5], r[R_START_H][7:6]};

  always_comb begin
    eol       = hcc_q == r[R_HTOTAL];
    hcc_d     = eol ? 8'd0 : hcc_q + 8'd1;
    raster_d  = raster_q;
    vcc_d     = vcc_q;
    vadj_d    = vadj_q;
    vstate_d  = vstate_q;
    ma_row_d  = ma_row_q;
    new_frame = 1'b0;
    if (eol) begin
      if (vstate_q == V_ADJUST) begin
        new_frame = vadj_q == r[R_VADJ][4:0] - 5'd1;
        vadj_d    = vadj_q + 5'd1;
        raster_d  = raster_q + 5'd1;
      end else if (raster_q == r[R_MAX_RA][4:0]) begin
        raster_d = '0;
        vcc_d    = vcc_q + 7'd1;
        ma_row_d = ma_row_q + {6'd0, r[R_HDISP]};
        if (vcc_q == r[R_VTOTAL][6:0]) begin
          new_frame = r[R_VADJ][4:0] == 5'd0;
          vstate_d  = new_frame ? V_ACTIVE : V_ADJUST;
          vadj_d    = '0;
        end
      end else begin
        raster_d = raster_q + 5'd1;
      end
      if (new_frame) begin
        vcc_d    = '0;
        raster_d = '0;
        ma_row_d = {r[R_START_H][5:0], r[R_START_L]};
        vstate_d = V_ACTIVE;
      end
    end
    // display/sync decisions use next-state counters so they line up with the character shown
    hdisp_d   = (hcc_d == 8'd0) ? 1'b1 : (hcc_d == r[R_HDISP]) ? 1'b0 : hdisp_q;
    row_start = eol && raster_d == 5'd0;
    vdisp_d   = (row_start && vcc_d == r[R_VDISP][6:0]) ? 1'b0 : new_frame ? 1'b1 : vdisp_q;
    hs_start  = hcc_d == r[R_HSYNC_POS] && !hsync_q && r[R_SYNC_W][3:0] != 4'd0;
    hsync_d   = hs_start || (hsync_q && hsw_q != r[R_SYNC_W][3:0]);
    hsw_d     = hs_start ? 4'd1 : hsync_d ? hsw_q + 4'd1 : 4'd0;
    vs_start  = row_start && vcc_d == r[R_VSYNC_POS][6:0] && !vsync_q;
    vsync_d   = vs_start || (vsync_q && !(eol && vsw_q == 5'(VSYNC_LINES - 1)));
    vsw_d     = vs_start ? 5'd0 : (vsync_q && eol) ? vsw_q + 5'd1 : vsw_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hcc_q    <= '0;
      raster_q <= '0;
      vcc_q    <= '0;
      vadj_q   <= '0;
      hsw_q    <= '0;
      vsw_q    <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hdisp_q  <= 1'b0;
      vdisp_q  <= 1'b1;
      vstate_q <= V_ACTIVE;
      ma_row_q <= {REG_RESET[R_START_H][5:0], REG_RESET[R_START_L]};
    end else if (CE) begin
      hcc_q    <= hcc_d;
      raster_q <= raster_d;
      vcc_q    <= vcc_d;
      vadj_q   <= vadj_d;
      hsw_q    <= hsw_d;
      vsw_q    <= vsw_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hdisp_q  <= hdisp_d;
      vdisp_q  <= vdisp_d;
      vstate_q <= vstate_d;
      ma_row_q <= ma_row_d;
    end
  end

  assign HSYNC = hsync_q;
  assign VSYNC = vsync_q;
  assign DE    = hdisp_q & vdisp_q;
  assign MA    = ma_row_q + {6'd0, hcc_q};
  assign RA    = raster_q;
endmodule

// File: tb/tb_amstrad_crtc.sv
// tb_amstrad_crtc: directed checks of frame timing, MA/RA sequence, register access and reset
module tb_amstrad_crtc;
  logic        CLK = 1'b0;
  logic        RESET, CE, SEL_WE, DATA_WE, DATA_RE;
  logic [7:0]  D, Q, v;
  logic        HSYNC, VSYNC, DE;
  logic [13:0] MA;
  logic [4:0]  RA;
  int          n_cmp = 0, n_bad = 0;
  localparam logic [63:0] HS_EXP = 64'h0FFF_C000_0000_0000;
  localparam logic [63:0] DE_EXP = 64'h0000_00FF_FFFF_FFFF;

  always #5 CLK = ~CLK;

  amstrad_crtc #(.VSYNC_LINES(16), .CRTC_TYPE(1)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .SEL_WE(SEL_WE), .DATA_WE(DATA_WE),
    .DATA_RE(DATA_RE), .D(D), .Q(Q), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
    .MA(MA), .RA(RA)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    CE = 1'b1;
    @(posedge CLK);
    #1 CE = 1'b0;
  endtask

  task automatic run_lines(input int n);
    repeat (n * 64) step();
  endtask

  task automatic sel(input logic [4:0] idx);
    SEL_WE = 1'b1; D = {3'b000, idx};
    @(posedge CLK);
    #1 SEL_WE = 1'b0;
  endtask

  task automatic reg_wr(input logic [4:0] idx, input logic [7:0] val);
    sel(idx);
    DATA_WE = 1'b1; D = val;
    @(posedge CLK);
    #1 DATA_WE = 1'b0;
  endtask

  task automatic rd_cur(output logic [7:0] val);
    DATA_RE = 1'b1;
    @(posedge CLK);
    #1 DATA_RE = 1'b0;
    val = Q;
  endtask

  task automatic reg_rd(input logic [4:0] idx, output logic [7:0] val);
    sel(idx);
    rd_cur(val);
  endtask

  task automatic line_vec(output logic [63:0] hs, output logic [63:0] de, output logic vs,
                          output logic [13:0] ma, output logic [4:0] ra);
    for (int h = 0; h < 64; h++) begin
      hs[h] = HSYNC;
      de[h] = DE;
      if (h == 0) begin
        vs = VSYNC; ma = MA; ra = RA;
      end
      step();
    end
  endtask

  task automatic check_frame();
    logic [63:0] hs, de;
    logic        vs;
    logic [13:0] ma;
    logic [4:0]  ra;
    int          ln;
    for (int l = 0; l <= 312; l++) begin
      ln = l % 312;
      line_vec(hs, de, vs, ma, ra);
      chk($sformatf("hsync l%0d", l), hs, HS_EXP);
      chk($sformatf("de l%0d", l), de, (l != 0 && ln < 200) ? DE_EXP : 64'd0);
      chk($sformatf("vsync l%0d", l), vs, 64'(ln >= 240 && ln <= 255));
      chk($sformatf("ma l%0d", l), ma, 64'(14'h3000 + 14'(ln / 8 * 40)));
      chk($sformatf("ra l%0d", l), ra, 64'(ln % 8));
    end
  endtask

  initial begin
    logic [63:0] hs, de;
    logic        vs;
    logic [13:0] ma;
    logic [4:0]  ra;
    RESET = 1'b1; CE = 1'b0; SEL_WE = 1'b0; DATA_WE = 1'b0; DATA_RE = 1'b0; D = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("rst hsync", HSYNC, 0);
    chk("rst vsync", VSYNC, 0);
    chk("rst de", DE, 0);
    chk("rst ma", MA, 14'h3000);
    chk("rst ra", RA, 0);
    chk("rst q", Q, 0);
    check_frame();
    chk("ma mid", MA, 14'h3000);
    reg_wr(14, 8'hFF); reg_rd(14, v); chk("rd r14", v, 8'h3F);
    reg_rd(12, v); chk("rd r12", v, 8'h00);
    reg_rd(31, v); chk("rd r31", v, 8'hFF);
    reg_wr(15, 8'hA5); reg_wr(20, 8'h5A);
    reg_rd(15, v); chk("rd r15", v, 8'hA5);
    reg_rd(14, v); chk("rd r14 again", v, 8'h3F);
    reg_rd(20, v); chk("rd r20", v, 8'h00);
    reg_wr(3, 8'h80);
    line_vec(hs, de, vs, ma, ra);
    chk("no hsync", hs, 64'd0);
    reg_wr(3, 8'h8E);
    line_vec(hs, de, vs, ma, ra);
    chk("hsync back", hs, HS_EXP);
    chk("de line2", de, DE_EXP);
    reg_wr(5, 8'd2); reg_wr(12, 8'h10); reg_wr(13, 8'h20);
    chk("ma l3", MA, 14'h3000);
    chk("ra l3", RA, 3);
    run_lines(97);
    chk("ma l100", MA, 14'h31E0);
    chk("ra l100", RA, 4);
    run_lines(212);
    chk("ma adj0", MA, 14'h3618);
    chk("ra adj0", RA, 0);
    chk("de adj0", DE, 0);
    run_lines(1);
    chk("ma adj1", MA, 14'h3618);
    chk("ra adj1", RA, 1);
    run_lines(1);
    chk("ma newframe", MA, 14'h1020);
    chk("ra newframe", RA, 0);
    reg_wr(5, 8'd0);
    run_lines(8);
    chk("ma row1", MA, 14'h1048);
    run_lines(142);
    chk("ma l150", MA, 14'h12F0);
    chk("ra l150", RA, 6);
    repeat (20) step();
    chk("ma l150 h20", MA, 14'h1304);
    chk("de l150 h20", DE, 1);
    reg_rd(31, v);
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    chk("rst2 hsync", HSYNC, 0);
    chk("rst2 vsync", VSYNC, 0);
    chk("rst2 de", DE, 0);
    chk("rst2 ma", MA, 14'h3000);
    chk("rst2 ra", RA, 0);
    chk("rst2 q", Q, 0);
    rd_cur(v); chk("rst2 sel", v, 8'h00);
    reg_rd(14, v); chk("rst2 r14", v, 8'h00);
    reg_rd(15, v); chk("rst2 r15", v, 8'h00);
    check_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/amstrad_crtc.md
Name: amstrad_crtc

Overview:
Character-clock CRTC (UM6845R, "type 1" behaviour subset) for the CPC core. It produces the crtc_hs, crtc_vs and crtc_de timing signals consumed by the gate array, plus the 14-bit memory address MA and 5-bit raster address RA used to build the video RAM address. The CPU programs it through the usual select/write ports (&BCxx select, &BDxx write, &BFxx read).

Parameters:
VSYNC_LINES, 16, fixed vsync length in scanlines (type 1 ignores R3[7:4]).
CRTC_TYPE, 1, read-back behaviour selector; only 1 is implemented, other values are illegal.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CE  in  1  1 MHz character-clock enable (gate array cyc1MHz)
SEL_WE  in  1  CPU write to the register-select latch
DATA_WE  in  1  CPU write to the selected register
DATA_RE  in  1  CPU read of the selected register or status
D  in  8  CPU write data
Q  out  8  CPU read data
HSYNC  out  1  crtc_hs
VSYNC  out  1  crtc_vs
DE  out  1  crtc_de (display enable)
MA  out  14  memory address
RA  out  5  raster address within the character row

Behaviour:
- Interface (already decided): a single clock, CLK. RESET is synchronous and active-high.
- Reset state:
  - Counters hcc, raster, vcc, vadj, hsw and vsw all 0.
  - HSYNC, VSYNC and DE are 0. MA=0x3000, RA=0, Q=0, select latch=0.
  - Register defaults: R0=63, R1=40, R2=46, R3=0x8E, R4=38, R5=0, R6=25, R7=30, R8=0, R9=7, R12=0x30, R13=0, R14=0, R15=0.
- Register interface (CLK-rate, not gated by CE):
  - SEL_WE latches D[4:0].
  - DATA_WE writes the selected register, masked to its width: R4/R6/R7 7 bits, R5/R9 5 bits, R12 6 bits, R14 6 bits, all others 8 bits.
  - Writes to index 16..31 are ignored. A written value is used from the next CE.
- Read-back (registered, one CLK after DATA_RE):
  - R14/R15 return their stored values.
  - R31 returns 0xFF.
  - All other indices return 0, including R12/R13 on type 1.
- All timing state advances only on CE. Outputs are registered and change in the CLK after the CE.
- Horizontal timing:
  - hcc counts 0..R0. When hcc==R0 it wraps to 0 (end of line).
  - hdisp goes to 1 at hcc==0 and to 0 when hcc==R1.
  - If R1>R0, hdisp stays 1 for the whole line.
- Hsync:
  - When hcc==R2 and hsync is inactive, HSYNC goes to 1 and hsw=1.
  - On each following CE hsw increments. HSYNC drops when hsw==R3[3:0].
  - If R3[3:0]==0, no hsync is generated.
  - An hsync in progress continues across the line wrap.
- Vertical timing, evaluated at end of line:
  - If raster==R9: raster=0, vcc++ and ma_row+=R1. Otherwise raster++.
  - If vcc==R4 and raster==R9: if R5==0 a new frame starts; otherwise the block enters the adjust state, where vadj counts lines 0..R5-1 and the new frame starts when vadj reaches R5-1.
- New frame: vcc=0, raster=0, vdisp=1, ma_row={R12[5:0],R13}.
- vdisp goes to 0 at the start of a row where vcc==R6. If R6>R4, vdisp stays 1.
- Vsync:
  - At the start of a row (raster 0) where vcc==R7 and vsync is inactive, VSYNC goes to 1 and vsw=0.
  - vsw increments at each end of line. VSYNC drops after VSYNC_LINES lines.
  - A vsync in progress continues through a new-frame wrap.
- Outputs:
  - DE = hdisp & vdisp.
  - MA = ma_row + hcc, 14-bit wrap.
  - RA = raster.
- Simultaneous events: when hcc==R0 and hcc==R2 in the same CE, the wrap and the hsync start both happen. When vcc==R6 and vcc==R7 in the same row, both take effect.
- RESET asserted mid-frame restores the full reset state in the next CLK, including register defaults.

Decomposition:
- Package amstrad_crtc_pkg holds:
  - register index localparams (R_HTOTAL … R_CURSOR_L)
  - reset-default constants
  - per-register width masks
  - the vertical state typedef {V_ACTIVE, V_ADJUST}
- Sub-module amstrad_crtc_regs holds the select latch, the masked register file and the read mux. The top level keeps the counters, sync generation and address generation.

Test Plan:
- Reset, then 64×313 CEs with default registers:
  - Line period is 64 CE.
  - HSYNC rises at hcc=46 and lasts 14 CE.
  - The frame is 312 lines.
  - VSYNC is high on lines 240..255.
  - DE is high for hcc 0..39 on lines 0..199 only.
- MA sequence with defaults: line 0 starts at MA=0x3000. Raster 7 of row 0 starts at 0x3000. Row 1 starts at 0x3028, with RA cycling 0..7.
- Write R5=2 → frame length becomes 314 lines. Write R3=0x80 → no HSYNC on any line.
- Write R12=0x10, R13=0x20 mid-frame → the current frame's MA is unchanged, and the next frame starts at MA=0x1020.
- Read-back: select 14 and write 0xFF → reading returns 0x3F. Select 12 → reading returns 0. Select 31 → reading returns 0xFF. Write to index 20 has no effect on any register.
- Assert RESET at line 150 for one CLK → all outputs return to reset values and the next frame timing matches the first scenario.
